// File: rtl/linebuf_window_ctrl_if.sv
// Pixel-in / line-memory / column-out bundle for linebuf_window_ctrl.
interface linebuf_window_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TAP_NUMS   = 3,
    parameter int LINE_CNT   = 12,
    parameter int ADDR_WIDTH = 12
);
    logic                               pix_valid_i;
    logic                               pix_ready_o;
    logic [DATA_WIDTH-1:0]              pix_data_i;
    logic                               sof_i;
    logic [LINE_CNT-1:0]                h_size_i;
    logic                               border_mode_i;
    logic                               rd_en_o;
    logic [ADDR_WIDTH-1:0]              rd_addr_o;
    logic [(TAP_NUMS-1)*DATA_WIDTH-1:0] rd_data_i;
    logic                               wr_en_o;
    logic [ADDR_WIDTH-1:0]              wr_addr_o;
    logic [(TAP_NUMS-1)*DATA_WIDTH-1:0] wr_data_o;
    logic                               col_valid_o;
    logic                               col_ready_i;
    logic [TAP_NUMS*DATA_WIDTH-1:0]     col_data_o;
    logic                               col_sof_o;
    logic                               col_eol_o;

    modport master (
        input  pix_valid_i, pix_data_i, sof_i, h_size_i, border_mode_i,
        input  rd_data_i, col_ready_i,
        output pix_ready_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o,
        output wr_data_o, col_valid_o, col_data_o, col_sof_o, col_eol_o
    );

    modport slave (
        output pix_valid_i, pix_data_i, sof_i, h_size_i, border_mode_i,
        output rd_data_i, col_ready_i,
        input  pix_ready_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o,
        input  wr_data_o, col_valid_o, col_data_o, col_sof_o, col_eol_o
    );
endinterface

// File: rtl/linebuf_window_ctrl.sv
// Line-buffer vertical window controller: S1 memory read, S2 column register.
// Define LINEBUF_ZERO_PAD_EN to enable zero padding via border_mode_i.
module linebuf_window_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TAP_NUMS   = 3,
    parameter int LINE_CNT   = 12,
    parameter int ADDR_WIDTH = 12
) (
    input logic                   clk,
    input logic                   rst,
    linebuf_window_ctrl_if.master bus
);
    localparam int NT  = TAP_NUMS - 1;
    localparam int RFW = $clog2(TAP_NUMS);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic                first_q;
    logic [LINE_CNT-1:0] col_q, col_d, h_q, h_d;
    logic [LINE_CNT-1:0] col_cur, h_cur;
    logic [RFW-1:0]      rf_q, rf_d, rf_cur;

    logic                s1_valid_q;
    pix_t                s1_pix_q;
    logic [LINE_CNT-1:0] s1_col_q;
    logic [RFW-1:0]      s1_rf_q;
    logic                s1_sof_q, s1_eol_q;

    logic                           col_valid_q, col_sof_q, col_eol_q;
    logic [TAP_NUMS*DATA_WIDTH-1:0] col_data_q, col_pack;
    logic [NT*DATA_WIDTH-1:0]       wr_pack;

    logic advance, accept, sof_eff, wrap;
    pix_t raw  [TAP_NUMS];
    pix_t taps [TAP_NUMS];
    pix_t rep;
    int   edge_s;

    assign advance         = ~col_valid_q | bus.col_ready_i;
    assign bus.pix_ready_o = ~s1_valid_q | advance;
    assign accept          = bus.pix_valid_i & bus.pix_ready_o & ~rst;

    // The first pixel after reset always opens a frame.
    assign sof_eff = bus.sof_i | first_q;
    assign col_cur = sof_eff ? '0 : col_q;
    assign rf_cur  = sof_eff ? '0 : rf_q;
    assign h_cur   = sof_eff ? bus.h_size_i : h_q;
    assign wrap    = (col_cur == h_cur - LINE_CNT'(1));

    always_comb begin
        col_d = col_q;
        rf_d  = rf_q;
        h_d   = h_q;
        if (accept) begin
            col_d = wrap ? '0 : col_cur + LINE_CNT'(1);
            rf_d  = (wrap && rf_cur != RFW'(NT)) ? rf_cur + RFW'(1) : rf_cur;
            h_d   = h_cur;
        end
    end

    assign bus.rd_en_o   = accept;
    assign bus.rd_addr_o = ADDR_WIDTH'(col_cur);

    always_comb begin
        for (int j = 0; j < NT; j++) begin
            raw[j] = bus.rd_data_i[j*DATA_WIDTH +: DATA_WIDTH];
        end
        raw[NT] = s1_pix_q;
    end

    // Taps below edge_s are not yet filled; edge_s itself is the oldest real line.
    always_comb begin
        edge_s = NT - int'(s1_rf_q);
        rep    = s1_pix_q;
        for (int j = 0; j < TAP_NUMS; j++) begin
            if (j == edge_s) rep = raw[j];
        end
        for (int j = 0; j < TAP_NUMS; j++) begin
            taps[j] = raw[j];
            if (j < edge_s) begin
`ifdef LINEBUF_ZERO_PAD_EN
                taps[j] = bus.border_mode_i ? '0 : rep;
`else
                taps[j] = rep;
`endif
            end
        end
    end

`ifndef LINEBUF_ZERO_PAD_EN
    logic unused_border;
    assign unused_border = bus.border_mode_i;
`endif

    always_comb begin
        col_pack = '0;
        wr_pack  = '0;
        for (int j = 0; j < TAP_NUMS; j++) begin
            col_pack[j*DATA_WIDTH +: DATA_WIDTH] = taps[j];
        end
        for (int j = 0; j < NT; j++) begin
            wr_pack[j*DATA_WIDTH +: DATA_WIDTH] = taps[j+1];
        end
    end

    assign bus.wr_en_o   = s1_valid_q & advance & ~rst;
    assign bus.wr_addr_o = ADDR_WIDTH'(s1_col_q);
    assign bus.wr_data_o = wr_pack;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q    <= 1'b1;
            col_q      <= '0;
            rf_q       <= '0;
            h_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_col_q   <= '0;
            s1_rf_q    <= '0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
        end else begin
            first_q <= first_q & ~accept;
            col_q   <= col_d;
            rf_q    <= rf_d;
            h_q     <= h_d;
            if (bus.pix_ready_o) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_pix_q <= bus.pix_data_i;
                    s1_col_q <= col_cur;
                    s1_rf_q  <= rf_cur;
                    s1_sof_q <= sof_eff;
                    s1_eol_q <= wrap;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_valid_q <= 1'b0;
            col_data_q  <= '0;
            col_sof_q   <= 1'b0;
            col_eol_q   <= 1'b0;
        end else if (advance) begin
            col_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                col_data_q <= col_pack;
                col_sof_q  <= s1_sof_q;
                col_eol_q  <= s1_eol_q;
            end
        end
    end

    assign bus.col_valid_o = col_valid_q;
    assign bus.col_data_o  = col_data_q;
    assign bus.col_sof_o   = col_sof_q;
    assign bus.col_eol_o   = col_eol_q;
endmodule

// File: doc/linebuf_window_ctrl.md
LINEBUF_WINDOW_CTRL -- requirements
Module: linebuf_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter TAP_NUMS, default 3: vertical taps, legal range 2..8.
REQ-003 SHALL have parameter LINE_CNT, default 12: width of h_size_i and of the column counter.
REQ-004 SHALL have parameter ADDR_WIDTH, default 12: line-memory address width, at least LINE_CNT.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_valid_i  in  1  input pixel valid.
- pix_ready_o  out  1  input pixel accepted when valid and ready are both high.
- pix_data_i  in  DATA_WIDTH  input pixel.
- sof_i  in  1  qualifies the accepted pixel as the first pixel of a frame.
- h_size_i  in  LINE_CNT  line length in pixels, 2 or more, sampled on the sof beat.
- border_mode_i  in  1  0 = replicate, 1 = zero pad.
- rd_en_o  out  1  line-memory read strobe.
- rd_addr_o  out  ADDR_WIDTH  line-memory read address.
- rd_data_i  in  (TAP_NUMS-1)*DATA_WIDTH  read data, 1-cycle latency, held while rd_en_o is low; slot j is tap j.
- wr_en_o, wr_addr_o, wr_data_o  out  1 / ADDR_WIDTH / (TAP_NUMS-1)*DATA_WIDTH  line-memory write.
- col_valid_o  out  1  column valid.
- col_ready_i  in  1  column accepted when col_valid_o and col_ready_i are both high.
- col_data_o  out  TAP_NUMS*DATA_WIDTH  column; slot 0 is the oldest line and slot TAP_NUMS-1 is the current pixel.
- col_sof_o, col_eol_o  out  1  column is the first of the frame / the last of the line.

Function
REQ-006 SHALL implement a two-stage pipeline, S1 (memory read) then S2 (output register); a pixel accepted in cycle t SHALL produce col_valid_o in cycle t+2 when there is no stall.
REQ-007 SHALL define advance = ~col_valid_o | col_ready_i and pix_ready_o = ~s1_valid | advance, both combinational.
REQ-008 SHALL, on each accepted pixel, assert rd_en_o with rd_addr_o = the current column count.
REQ-009 SHALL keep a column counter that increments per accepted pixel and wraps from h_size-1 to 0.
REQ-010 SHALL keep row_fill, saturating at TAP_NUMS-1, that increments on each wrap.
REQ-011 SHALL, on an accepted pixel with sof_i high, force the column counter and row_fill to 0 before use, including when this occurs mid-line, and SHALL latch h_size_i.
REQ-012 SHALL treat tap j (j < TAP_NUMS-1) as valid when j >= TAP_NUMS-1-row_fill, using the row_fill value carried with the S1 pixel.
REQ-013 SHALL drive each invalid tap as follows:
- replicate mode: the value of tap TAP_NUMS-1-row_fill, which is the pixel itself when row_fill = 0;
- zero mode: 0.
REQ-014 SHALL, when S1 advances into S2, assert wr_en_o for one cycle with wr_addr_o = the S1 column and wr_data_o = the substituted taps 1..TAP_NUMS-1.
REQ-015 SHALL emit columns from the first line of a frame onward; unlike the previous generation, border lines are not suppressed.
REQ-016 SHALL, when stalled (advance = 0), hold col_data_o, col_sof_o and col_eol_o stable and issue no reads or writes, so that no pixel is lost or duplicated.
REQ-017 SHALL assert col_eol_o when the column equals h_size-1, and col_sof_o on the column of the sof pixel.

Reset
REQ-018 SHALL, while rst is high, clear s1_valid, col_valid_o, rd_en_o, wr_en_o, both counters, col_sof_o and col_eol_o, and clear col_data_o to 0.
REQ-019 SHALL drive pix_ready_o to 1 in the first cycle after rst falls.
REQ-020 SHALL treat the first pixel after reset as a frame start whether or not sof_i is high.

Configuration
REQ-021 SHALL honour the macro LINEBUF_ZERO_PAD_EN:
- defined: border_mode_i selects replicate or zero mode;
- undefined: border_mode_i is ignored, replicate mode is always used, and no zero-pad logic is synthesised.

Verification
REQ-022 Reset: hold rst high for 2 cycles with pix_valid_i high -> no rd_en_o, wr_en_o or col_valid_o; pix_ready_o = 1 after release.
REQ-023 Replicate, TAP_NUMS=3, h_size=4, frame of pixels 10-13 / 20-23 / 30-33 -> columns {10,10,10}, {20,10,10}, {30,20,10} (newest..oldest); col_eol_o on the 4th column of each line; latency of 2 cycles.
REQ-024 Zero pad with LINEBUF_ZERO_PAD_EN defined and the same stimulus -> {10,0,0}, {20,10,0}, {30,20,10}; without the macro -> the replicate results.
REQ-025 Backpressure: col_ready_i low for 3 cycles mid-line -> col_data_o held, pix_ready_o low after one pixel, no wr_en_o, and the full sequence delivered intact afterwards.
REQ-026 Mid-line sof: sof_i at column 2 of line 3 -> column counter restarts at 0, the column is {p,p,p}, and col_sof_o is high on that column.
